// File: rtl/restoring_div_16_pkg.sv
// Shared constants and state encoding for the 16-bit restoring divider.
// Imported by the divider top and its testbench.
package restoring_div_16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [15:0] DBZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/restoring_div_16_cla.sv
// 16-bit carry-lookahead adder, 4-bit groups with a lookahead group-carry stage.
// Combinational; sub_i=1 computes a_i - b_i, and cout_o=1 then means no borrow.
module cla_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] bx;
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] ci;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign bx = b_i ^ {16{sub_i}};
  assign g  = a_i & bx;
  assign p  = a_i ^ bx;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign gp[k] = &p[4*k +: 4];

    assign ci[4*k]   = gc[k];
    assign ci[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
    assign ci[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
    assign ci[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
  end

  // Subtract mode supplies the +1 of two's complement as the carry-in.
  assign gc[0] = sub_i;
  assign gc[1] = gg[0] | (gp[0] & gc[0]);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & gc[0]);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

  assign sum_o  = p ^ ci;
  assign cout_o = gc[4];

endmodule

// File: rtl/restoring_div_16.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock; done 17 clocks
// after accept (1 clock for divide-by-zero). Accepts start only while ready; busy starts are dropped.
module restoring_div_16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import restoring_div_16_pkg::*;

  if (WIDTH != 16 || (1 << CNT_W) <= WIDTH) begin : g_param_check
    $error("restoring_div_16: WIDTH must be 16 and CNT_W must hold 0..WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             carry_out;
  logic             no_borrow;

  assign shifted = {r_q, q_q[WIDTH-1]};

  cla_16 u_cla (
    .a_i    (shifted[WIDTH-1:0]),
    .b_i    (d_q),
    .sub_i  (1'b1),
    .sum_o  (trial),
    .cout_o (carry_out)
  );

  // The partial remainder always stays below D, so a successful trial fits in WIDTH bits.
  assign no_borrow = shifted[WIDTH] | carry_out;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quot_d  = DBZ_QUOT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (no_borrow) begin
          r_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == FIN);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div_16.sv
// Scoreboarded bench for restoring_div_16: directed corner cases, busy-start, mid-run reset
// and random operand pairs against a plain-arithmetic reference.
module tb_restoring_div_16;

  import restoring_div_16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  restoring_div_16 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          issue_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int c);
    exp_t e;
    e.a = a;
    e.b = b;
    e.issue_cyc = c;
    if (b == 16'd0) begin
      e.q = DBZ_QUOT;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_has_request", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.dbz);
        chk("latency", longint'(cyc - mon_e.issue_cyc), mon_e.dbz ? 1 : 17);
        chk("ready_low_at_done", ready, 0);
        if (!mon_e.dbz) begin
          chk("invariant_sum", 32'(quotient) * 32'(mon_e.b) + 32'(remainder), 32'(mon_e.a));
          chk("invariant_rem_lt_div", longint'(remainder < mon_e.b), 1);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("issue_ready_timeout", ready, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, cyc));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();

    issue(16'd100, 16'd7);
    drain();
    chk("hold_quotient", quotient, 14);
    issue(16'hFFFF, 16'h0001);
    issue(16'hFFFF, 16'h8000);
    issue(16'd3, 16'd10);
    issue(16'd0, 16'd5);
    issue(16'd1234, 16'd0);
    issue(16'd9, 16'd3);
    drain();

    // Start raised while busy must be dropped, not queued.
    issue(16'd100, 16'd7);
    repeat (2) @(negedge clk);
    chk("busy_ready_low", ready, 0);
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("busy_hold_quotient", quotient, 14);
    chk("busy_hold_remainder", remainder, 2);
    issue(16'd50, 16'd5);
    drain();

    // Reset in the middle of a run discards the division.
    issue(16'd1000, 16'd3);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset_state();
    repeat (20) @(negedge clk);
    issue(16'd200, 16'd9);
    drain();

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      int unsigned sel;
      a   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 16'd0;
      else if (sel <= 3) b = 16'($urandom_range(1, 15));
      else if (sel == 4) b = 16'h8000 | 16'($urandom);
      else               b = 16'($urandom);
      issue(a, b);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
